// File: rtl/key_cmd_gen_if.sv
// key_cmd_gen_if: button/command bundle for key_cmd_gen.
//   key_raw          raw push buttons (bit0 add, 1 sub, 2 shift-left, 3 shift-right)
//   key_add..right   one-cycle command pulses, mutually exclusive
//   key_state        debounced level per key, 1 = pressed
//   cmd_pending      at least one command still waiting to issue
// master = button side / consumer (drives key_raw), slave = key_cmd_gen.
interface key_cmd_gen_if;
  logic [3:0] key_raw;
  logic       key_add;
  logic       key_sub;
  logic       key_shift_left;
  logic       key_shift_right;
  logic [3:0] key_state;
  logic       cmd_pending;

  modport master (
    output key_raw,
    input  key_add, key_sub, key_shift_left, key_shift_right, key_state, cmd_pending
  );

  modport slave (
    input  key_raw,
    output key_add, key_sub, key_shift_left, key_shift_right, key_state, cmd_pending
  );
endinterface

// File: rtl/key_cmd_gen.sv
// key_cmd_gen: turns four bouncy asynchronous buttons into clean, mutually
// exclusive single-cycle commands (add > sub > shift_left > shift_right).
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    key_cmd_gen_if.slave (key_raw in; commands, key_state, cmd_pending out)
// Optional macro KEY_AUTO_REPEAT_EN: held keys re-request after REPEAT_DELAY,
// then every REPEAT_PERIOD cycles. Undefined: one pulse per debounced press.

// Per-key lane: 2-flop synchroniser, debounce, press detect, optional repeat.
module key_cmd_lane #(
  parameter int unsigned      CNT_W          = 2,
  parameter logic [CNT_W-1:0] DB_LAST        = '1,
  parameter bit               KEY_ACTIVE_LOW = 1'b1
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter logic [31:0]      REPEAT_DELAY   = 32'd25_000_000,
  parameter logic [31:0]      REPEAT_PERIOD  = 32'd5_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
`ifdef KEY_AUTO_REPEAT_EN
  input  logic issued,
`endif
  output logic state,
  output logic req
);
  // Sync flops idle at the released level so reset never looks like a press.
  localparam logic [1:0] SYNC_IDLE = KEY_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level, flip, rise;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= SYNC_IDLE;
    else       sync <= {sync[0], raw};

  assign level = sync[1] ^ KEY_ACTIVE_LOW;   // 1 = pressed
  // The D-th consecutive differing sample flips the state.
  assign flip  = (level != state) && (cnt == DB_LAST);
  assign rise  = flip & ~state;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (level == state) begin
      cnt   <= '0;
    end else if (cnt == DB_LAST) begin
      cnt   <= '0;
      state <= ~state;
    end else begin
      cnt   <= cnt + 1'b1;
    end

`ifdef KEY_AUTO_REPEAT_EN
  // rpt_cnt counts cycles since this key last issued (1 on the cycle after).
  // rpt_long selects the initial delay for the first repeat after a press.
  logic [31:0] rpt_cnt;
  logic        rpt_run, rpt_seen, rpt_long, fall, rpt_hit;

  assign fall    = flip & state;
  assign rpt_hit = rpt_run && !fall &&
                   (rpt_cnt == (rpt_long ? REPEAT_DELAY : REPEAT_PERIOD) - 32'd1);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rpt_cnt  <= '0;
      rpt_run  <= 1'b0;
      rpt_seen <= 1'b0;
      rpt_long <= 1'b0;
    end else if (fall) begin
      rpt_cnt  <= '0;
      rpt_run  <= 1'b0;
      rpt_seen <= 1'b0;
    end else if (issued && state) begin
      rpt_cnt  <= 32'd1;
      rpt_run  <= 1'b1;
      rpt_long <= ~rpt_seen;
      rpt_seen <= 1'b1;
    end else if (rpt_hit) begin
      rpt_run  <= 1'b0;                     // re-armed when the repeat issues
    end else if (rpt_run) begin
      rpt_cnt  <= rpt_cnt + 32'd1;
    end

  assign req = rise | rpt_hit;
`else
  assign req = rise;
`endif
endmodule

module key_cmd_gen #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter logic [31:0] REPEAT_DELAY    = 32'd25_000_000,
  parameter logic [31:0] REPEAT_PERIOD   = 32'd5_000_000
) (
  input  logic          clk,
  input  logic          reset,
  key_cmd_gen_if.slave  bus
);
  localparam int unsigned      NUM_KEYS = 4;
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  logic [NUM_KEYS-1:0] state, req, pending, issue, cmd;

  // Lowest set bit = highest priority (add is bit 0).
  assign issue = pending & (~pending + 4'd1);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_cmd_lane #(
      .CNT_W          (CNT_W),
      .DB_LAST        (DB_LAST),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
`ifdef KEY_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .raw    (bus.key_raw[i]),
`ifdef KEY_AUTO_REPEAT_EN
      .issued (issue[i]),
`endif
      .state  (state[i]),
      .req    (req[i])
    );
  end

  // A request landing on an already-set flag coalesces into it; a request
  // on the flag being issued this cycle survives as a fresh entry.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      cmd     <= '0;
    end else begin
      pending <= (pending & ~issue) | req;
      cmd     <= issue;
    end

  assign bus.key_add         = cmd[0];
  assign bus.key_sub         = cmd[1];
  assign bus.key_shift_left  = cmd[2];
  assign bus.key_shift_right = cmd[3];
  assign bus.key_state       = state;
  assign bus.cmd_pending     = |pending;
endmodule
